// File: rtl/ahb_axi_pkg.sv
// Shared encodings for the AHB-Lite to AXI4-Lite bridge.
package ahb_axi_pkg;

    // AHB HTRANS encodings
    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    // AHB HSIZE codes supported by a 32-bit data path
    localparam logic [2:0] HsizeByte = 3'b000;
    localparam logic [2:0] HsizeHalf = 3'b001;
    localparam logic [2:0] HsizeWord = 3'b010;

    // AXI response codes
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    // Bridge FSM states
    typedef enum logic [2:0] {
        StIdle,
        StWdata,
        StWaddr,
        StWresp,
        StRaddr,
        StRwait,
        StErr1,
        StErr2
    } state_e;

    // SLVERR and DECERR map to an AHB ERROR; OKAY and EXOKAY map to OKAY.
    function automatic logic resp_is_err(logic [1:0] resp);
        return (resp == RespSlverr) || (resp == RespDecerr);
    endfunction

endpackage

// File: rtl/ahb_to_axi4lite_bridge_if.sv
// Bundle of the AHB-Lite slave port and the AXI4-Lite master port of the bridge.
// The slave modport is the bridge's view; master is the environment's view
// (AHB master plus AXI slave).
interface ahb_to_axi4lite_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    // AHB-Lite side
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;

    // AXI4-Lite side
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [31:0]           RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/ahb_wstrb_gen.sv
// Combinational byte-lane strobe and alignment check from AHB size/address.
module ahb_wstrb_gen
    import ahb_axi_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb,
    output logic       misalign
);

    // Decode lane strobes; sizes wider than a word are flagged as misaligned.
    always_comb begin
        wstrb    = 4'b0000;
        misalign = 1'b0;
        case (hsize)
            HsizeByte: wstrb = 4'b0001 << addr_lo;
            HsizeHalf: begin
                wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
                misalign = addr_lo[0];
            end
            HsizeWord: begin
                wstrb    = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default:   misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_to_axi4lite_bridge.sv
// AHB-Lite slave to AXI4-Lite master bridge: one outstanding transfer at a time,
// all bus-facing outputs registered.
module ahb_to_axi4lite_bridge
    import ahb_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic                     ACLK,
    input logic                     ARESET,
    ahb_to_axi4lite_bridge_if.slave bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic [31:0]           hrdata_q, hrdata_d;

    logic [3:0] strb;
    logic       misalign;
    logic       accept;

    ahb_wstrb_gen u_wstrb_gen (
        .hsize    (bus.HSIZE),
        .addr_lo  (bus.HADDR[1:0]),
        .wstrb    (strb),
        .misalign (misalign)
    );

    assign accept = bus.HSEL && bus.HREADY &&
                    ((bus.HTRANS == HtransNonseq) || (bus.HTRANS == HtransSeq));

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.AWADDR    = haddr_q;
    assign bus.AWVALID   = awvalid_q;
    assign bus.WDATA     = wdata_q;
    assign bus.WSTRB     = wstrb_q;
    assign bus.WVALID    = wvalid_q;
    assign bus.BREADY    = bready_q;
    assign bus.ARADDR    = haddr_q;
    assign bus.ARVALID   = arvalid_q;
    assign bus.RREADY    = rready_q;

    // Next-state and next-output decode; outputs are derived from the next state
    // so that they come straight out of flops.
    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        hrdata_d  = hrdata_q;

        unique case (state_q)
            StIdle, StErr2: begin
                state_d = StIdle;
                if (accept) begin
                    haddr_d = bus.HADDR;
                    wstrb_d = strb;
                    if (misalign) begin
                        state_d = StErr1;
                    end else if (bus.HWRITE) begin
                        state_d = StWdata;
                    end else begin
                        state_d   = StRaddr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWdata: begin
                wdata_d   = bus.HWDATA;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = StWaddr;
            end
            StWaddr: begin
                // AW and W complete independently; wait for both.
                if (bus.AWREADY) awvalid_d = 1'b0;
                if (bus.WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = StWresp;
                    bready_d = 1'b1;
                end
            end
            StWresp: begin
                if (bus.BVALID) begin
                    bready_d = 1'b0;
                    state_d  = resp_is_err(bus.BRESP) ? StErr1 : StIdle;
                end
            end
            StRaddr: begin
                if (bus.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRwait;
                end
            end
            StRwait: begin
                if (bus.RVALID) begin
                    rready_d = 1'b0;
                    if (resp_is_err(bus.RRESP)) begin
                        state_d = StErr1;
                    end else begin
                        state_d  = StIdle;
                        hrdata_d = bus.RDATA;
                    end
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase

        hreadyout_d = (state_d == StIdle) || (state_d == StErr2);
        hresp_d     = (state_d == StErr1) || (state_d == StErr2);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= StIdle;
            haddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_to_axi4lite_bridge.sv
// Bench for the AHB-Lite to AXI4-Lite bridge: a per-transfer timeline model
// built from the bridge's latency rules, checked every cycle, plus literal pins.
module tb_ahb_to_axi4lite_bridge;

    localparam int MaxK = 64;

    logic ACLK = 1'b0;
    logic ARESET;

    always #5 ACLK = ~ACLK;

    ahb_to_axi4lite_bridge_if #(.ADDR_WIDTH(32)) bus ();

    ahb_to_axi4lite_bridge #(.ADDR_WIDTH(32)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    // Expected outputs and scheduled AXI-slave inputs, indexed by cycle after accept
    logic        e_rdy [MaxK];
    logic        e_resp [MaxK];
    logic        e_awv [MaxK];
    logic        e_wv [MaxK];
    logic        e_bready [MaxK];
    logic        e_arv [MaxK];
    logic        e_rready [MaxK];
    logic        e_zero [MaxK];
    logic [31:0] e_hrdata [MaxK];
    logic        i_awready [MaxK];
    logic        i_wready [MaxK];
    logic        i_bvalid [MaxK];
    logic        i_arready [MaxK];
    logic        i_rvalid [MaxK];

    int          len;
    bit          t_noop;
    bit          t_write;
    logic [2:0]  t_size;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [1:0]  t_resp;
    logic [31:0] t_rdata;
    logic [3:0]  t_wstrb;
    int          t_rst_k;
    logic [31:0] model_hrdata = 32'h0;

    int          total = 0;
    int          bad = 0;
    bit          check_en = 1'b0;
    int          cmp_k = 0;
    bit          pin_en = 1'b0;
    string       pin_name = "";
    logic [31:0] pin_act = 32'h0;
    logic [31:0] pin_exp = 32'h0;

    int          obs_awv, obs_wv, obs_arv, obs_err, obs_rdy_k;
    logic [31:0] obs_awaddr, obs_wdata, obs_hrdata;
    logic [3:0]  obs_wstrb;

    task automatic chk1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%b want=%b", name, cmp_k, act, exp);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%h want=%h", name, cmp_k, act, exp);
        end
    endtask

    // Compare process: per-cycle model checks, observation capture, literal pins.
    always @(negedge ACLK) begin
        int k;
        if (pin_en) chk32(pin_name, pin_act, pin_exp);
        if (check_en) begin
            k = cmp_k;
            if (k == 0) begin
                obs_awv = 0; obs_wv = 0; obs_arv = 0; obs_err = 0; obs_rdy_k = -1;
                obs_awaddr = 32'h0; obs_wdata = 32'h0; obs_wstrb = 4'h0;
            end
            chk1("hreadyout", bus.HREADYOUT, e_rdy[k]);
            chk1("hresp", bus.HRESP, e_resp[k]);
            chk32("hrdata", bus.HRDATA, e_hrdata[k]);
            chk1("awvalid", bus.AWVALID, e_awv[k]);
            chk1("wvalid", bus.WVALID, e_wv[k]);
            chk1("bready", bus.BREADY, e_bready[k]);
            chk1("arvalid", bus.ARVALID, e_arv[k]);
            chk1("rready", bus.RREADY, e_rready[k]);
            if (e_awv[k]) chk32("awaddr", bus.AWADDR, t_addr);
            if (e_wv[k]) begin
                chk32("wdata", bus.WDATA, t_wdata);
                chk32("wstrb", {28'h0, bus.WSTRB}, {28'h0, t_wstrb});
            end
            if (e_arv[k]) chk32("araddr", bus.ARADDR, t_addr);
            if (e_zero[k]) begin
                chk32("awaddr_rst", bus.AWADDR, 32'h0);
                chk32("araddr_rst", bus.ARADDR, 32'h0);
                chk32("wdata_rst", bus.WDATA, 32'h0);
                chk32("wstrb_rst", {28'h0, bus.WSTRB}, 32'h0);
            end
            if (bus.AWVALID) obs_awv++;
            if (bus.WVALID) obs_wv++;
            if (bus.ARVALID) obs_arv++;
            if (bus.HRESP) obs_err++;
            if (bus.AWVALID && bus.AWREADY) obs_awaddr = bus.AWADDR;
            if (bus.WVALID && bus.WREADY) begin
                obs_wdata = bus.WDATA;
                obs_wstrb = bus.WSTRB;
            end
            if (k >= 1 && bus.HREADYOUT && obs_rdy_k < 0) obs_rdy_k = k;
            obs_hrdata = bus.HRDATA;
        end
    end

    // Timeline model: a transfer accepted in cycle 0 follows the bridge's latency rules.
    task automatic build(bit noop, bit write, logic [2:0] size, logic [31:0] addr,
                         logic [31:0] wdata, int da, int dw, int dd, logic [1:0] resp,
                         logic [31:0] rdata, int rst_k);
        bit mis;
        int m;
        int c;
        t_noop = noop; t_write = write; t_size = size; t_addr = addr; t_wdata = wdata;
        t_resp = resp; t_rdata = rdata; t_rst_k = rst_k;
        case (size)
            3'd0:    t_wstrb = 4'b0001 << addr[1:0];
            3'd1:    t_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            default: t_wstrb = 4'b1111;
        endcase
        mis = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
        for (int k = 0; k < MaxK; k++) begin
            e_rdy[k] = 1'b1; e_resp[k] = 1'b0; e_awv[k] = 1'b0; e_wv[k] = 1'b0;
            e_bready[k] = 1'b0; e_arv[k] = 1'b0; e_rready[k] = 1'b0; e_zero[k] = 1'b0;
            e_hrdata[k] = model_hrdata;
            i_awready[k] = 1'b0; i_wready[k] = 1'b0; i_bvalid[k] = 1'b0;
            i_arready[k] = 1'b0; i_rvalid[k] = 1'b0;
        end
        if (noop) begin
            len = 4;
        end else if (mis) begin
            e_rdy[1] = 1'b0; e_resp[1] = 1'b1; e_resp[2] = 1'b1;
            len = 4;
        end else begin
            if (write) begin
                for (int k = 2; k <= 2 + da; k++) e_awv[k] = 1'b1;
                for (int k = 2; k <= 2 + dw; k++) e_wv[k] = 1'b1;
                i_awready[2 + da] = 1'b1;
                i_wready[2 + dw] = 1'b1;
                m = 2 + ((da > dw) ? da : dw);
            end else begin
                for (int k = 1; k <= 1 + da; k++) e_arv[k] = 1'b1;
                i_arready[1 + da] = 1'b1;
                m = 1 + da;
            end
            c = m + 1 + dd;
            for (int k = m + 1; k <= c; k++) begin
                if (write) e_bready[k] = 1'b1;
                else e_rready[k] = 1'b1;
            end
            if (write) i_bvalid[c] = 1'b1;
            else i_rvalid[c] = 1'b1;
            for (int k = 1; k <= c; k++) e_rdy[k] = 1'b0;
            if (resp[1]) begin
                e_rdy[c + 1] = 1'b0; e_resp[c + 1] = 1'b1; e_resp[c + 2] = 1'b1;
            end else if (!write) begin
                model_hrdata = rdata;
                for (int k = c + 1; k < MaxK; k++) e_hrdata[k] = rdata;
            end
            len = c + 4;
        end
        if (rst_k >= 0) begin
            for (int k = rst_k; k < MaxK; k++) begin
                i_awready[k] = 1'b0; i_wready[k] = 1'b0; i_bvalid[k] = 1'b0;
                i_arready[k] = 1'b0; i_rvalid[k] = 1'b0;
            end
            for (int k = rst_k + 1; k < MaxK; k++) begin
                e_rdy[k] = 1'b1; e_resp[k] = 1'b0; e_awv[k] = 1'b0; e_wv[k] = 1'b0;
                e_bready[k] = 1'b0; e_arv[k] = 1'b0; e_rready[k] = 1'b0;
                e_zero[k] = 1'b1; e_hrdata[k] = 32'h0;
            end
            len = rst_k + 3;
            model_hrdata = 32'h0;
        end
    endtask

    task automatic drive_idle();
        bus.HSEL = 1'b0; bus.HADDR = 32'h0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'b000; bus.HWDATA = 32'h0; bus.HREADY = 1'b1;
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BRESP = 2'b00; bus.BVALID = 1'b0;
        bus.ARREADY = 1'b0; bus.RDATA = 32'h0; bus.RRESP = 2'b00; bus.RVALID = 1'b0;
    endtask

    task automatic run();
        for (int k = 0; k < len; k++) begin
            @(posedge ACLK);
            #1;
            if (t_noop) begin
                bus.HSEL   = (k == 1 || k == 2);
                bus.HTRANS = (k == 1) ? 2'b01 : ((k == 2) ? 2'b10 : 2'b00);
                bus.HREADY = (k != 2);
                bus.HADDR  = 32'h1000;
                bus.HWRITE = 1'b1;
                bus.HSIZE  = 3'b010;
            end else begin
                bus.HSEL   = (k == 0);
                bus.HTRANS = (k == 0) ? 2'b10 : 2'b00;
                bus.HADDR  = (k == 0) ? t_addr : 32'h0;
                bus.HWRITE = (k == 0) && t_write;
                bus.HSIZE  = (k == 0) ? t_size : 3'b000;
                bus.HREADY = 1'b1;
            end
            bus.HWDATA  = (k == 1 && !t_noop) ? t_wdata : 32'h0;
            bus.AWREADY = i_awready[k];
            bus.WREADY  = i_wready[k];
            bus.BVALID  = i_bvalid[k];
            bus.BRESP   = i_bvalid[k] ? t_resp : 2'b00;
            bus.ARREADY = i_arready[k];
            bus.RVALID  = i_rvalid[k];
            bus.RRESP   = i_rvalid[k] ? t_resp : 2'b00;
            bus.RDATA   = i_rvalid[k] ? t_rdata : 32'h0;
            ARESET      = (k == t_rst_k);
            cmp_k       = k;
            check_en    = 1'b1;
        end
        @(posedge ACLK);
        #1;
        check_en = 1'b0;
        ARESET   = 1'b0;
        drive_idle();
    endtask

    task automatic do_reset();
        @(posedge ACLK);
        #1;
        drive_idle();
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        model_hrdata = 32'h0;
    endtask

    task automatic pin(string name, logic [31:0] act, logic [31:0] exp);
        pin_name = name;
        pin_act  = act;
        pin_exp  = exp;
        pin_en   = 1'b1;
        @(negedge ACLK);
        #1;
        pin_en = 1'b0;
    endtask

    initial begin
        drive_idle();
        ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        // Reset state plus BUSY and HREADY-low selects: zero-wait OKAY, no AXI activity
        build(1, 0, 3'd2, 32'h0, 32'h0, 0, 0, 0, 2'b00, 32'h0, -1);
        run();
        pin("noop_err", obs_err, 0);
        pin("noop_axi", obs_awv + obs_arv, 0);

        // Word write, everything ready at once
        do_reset();
        build(0, 1, 3'd2, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 2'b00, 32'h0, -1);
        run();
        pin("w1_awaddr", obs_awaddr, 32'h0000_1000);
        pin("w1_wstrb", {28'h0, obs_wstrb}, 32'hF);
        pin("w1_wdata", obs_wdata, 32'hDEADBEEF);
        pin("w1_rdy_cycle", obs_rdy_k, 4);
        pin("w1_err", obs_err, 0);

        // Byte read with ARREADY held off three cycles
        do_reset();
        build(0, 0, 3'd0, 32'h2003, 32'h0, 3, 0, 0, 2'b00, 32'h11223344, -1);
        run();
        pin("r1_arv_cycles", obs_arv, 4);
        pin("r1_hrdata", obs_hrdata, 32'h11223344);
        pin("r1_rdy_cycle", obs_rdy_k, 6);

        // WREADY two cycles ahead of AWREADY, SLVERR response
        do_reset();
        build(0, 1, 3'd2, 32'h4000, 32'hCAFEF00D, 2, 0, 1, 2'b10, 32'h0, -1);
        run();
        pin("w2_awv_cycles", obs_awv, 3);
        pin("w2_wv_cycles", obs_wv, 1);
        pin("w2_err", obs_err, 2);
        pin("w2_rdy_cycle", obs_rdy_k, 8);

        // Oversized transfer
        do_reset();
        build(0, 1, 3'd3, 32'h5000, 32'h12345678, 0, 0, 0, 2'b00, 32'h0, -1);
        run();
        pin("sz_err", obs_err, 2);
        pin("sz_axi", obs_awv + obs_arv, 0);
        pin("sz_rdy_cycle", obs_rdy_k, 2);

        // Misaligned halfword read
        do_reset();
        build(0, 0, 3'd1, 32'h3001, 32'h0, 0, 0, 0, 2'b00, 32'h0, -1);
        run();
        pin("mh_err", obs_err, 2);
        pin("mh_axi", obs_awv + obs_arv, 0);

        // Upper halfword write
        do_reset();
        build(0, 1, 3'd1, 32'h3002, 32'hBEEF0000, 1, 0, 0, 2'b00, 32'h0, -1);
        run();
        pin("hw_wstrb", {28'h0, obs_wstrb}, 32'hC);

        // Byte write to lane 1, W handshake late
        do_reset();
        build(0, 1, 3'd0, 32'h1001, 32'h0000AB00, 0, 1, 0, 2'b00, 32'h0, -1);
        run();
        pin("bw_wstrb", {28'h0, obs_wstrb}, 32'h2);

        // EXOKAY read maps to OKAY
        do_reset();
        build(0, 0, 3'd2, 32'h6000, 32'h0, 0, 0, 2, 2'b01, 32'hA5A5_5A5A, -1);
        run();
        pin("ex_hrdata", obs_hrdata, 32'hA5A5_5A5A);
        pin("ex_err", obs_err, 0);

        // DECERR read
        do_reset();
        build(0, 0, 3'd2, 32'h7000, 32'h0, 0, 0, 0, 2'b11, 32'h0BAD_0BAD, -1);
        run();
        pin("de_err", obs_err, 2);
        pin("de_hrdata", obs_hrdata, 32'h0);

        // Reset while waiting on ARREADY
        do_reset();
        build(0, 0, 3'd2, 32'h8000, 32'h0, 10, 0, 0, 2'b00, 32'h0, 2);
        run();
        pin("rst_arv_cycles", obs_arv, 2);
        pin("rst_rdy_cycle", obs_rdy_k, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
